// File: rtl/mem_pkg.sv
// Shared definitions for the external-memory arbiter and its helpers.
// Optional build macro used by mem_arbiter: MEM_ARB_ROUND_ROBIN_EN.
package mem_pkg;

    // One-hot arbiter states
    typedef enum logic [2:0] {
        MEM_ARB_IDLE    = 3'b001,
        MEM_ARB_ISSUE   = 3'b010,
        MEM_ARB_RELEASE = 3'b100
    } mem_arb_state_t;

    // Requester IDs
    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_LS = 1'b1;

    // Command width used by the SPI engine
    localparam int SPI_CMD_BITS = 8;

    // Transfer sizes in bytes
    localparam logic [2:0] SIZE_B = 3'd1;
    localparam logic [2:0] SIZE_H = 3'd2;
    localparam logic [2:0] SIZE_W = 3'd4;

    // Anything other than a byte or halfword is treated as a full word,
    // matching what the engine itself does with odd byte counts.
    function automatic logic [2:0] coerce_size(input logic [2:0] s);
        return (s == SIZE_B || s == SIZE_H) ? s : SIZE_W;
    endfunction

endpackage

// File: rtl/mem_rdata_fmt.sv
// Converts the engine's MSB-first fetched value into a little-endian,
// zero-extended word for the requester.
module mem_rdata_fmt
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        size,
    input  logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] fmt
);

    // Byte swap selected by transfer size; unused upper bytes read as zero
    always_comb begin
        fmt = '0;
        case (size)
            SIZE_B:  fmt[7:0]  = raw[7:0];
            SIZE_H:  fmt[15:0] = {raw[7:0], raw[15:8]};
            default: fmt[31:0] = {raw[7:0], raw[15:8], raw[23:16], raw[31:24]};
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the SPI memory engine between instruction fetch and load/store.
// Build option: define MEM_ARB_ROUND_ROBIN_EN to alternate grants on
// simultaneous requests; otherwise load/store always wins a tie.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic              ls_we,
    input  logic [2:0]        ls_size,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_start,
    output logic [2:0]        mem_num_bytes,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_is_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    mem_arb_state_t    state_q, state_d;
    logic              start_q, start_d;
    logic              if_ack_q, if_ack_d, ls_ack_q, ls_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [2:0]        size_q, size_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              owner_q, owner_d;
    logic              busy_q, busy_d;
    logic              grant_ls;
    logic [DATA_W-1:0] fmt_rdata;

    mem_rdata_fmt #(.DATA_W(DATA_W)) u_fmt (
        .size (size_q),
        .raw  (mem_rdata),
        .fmt  (fmt_rdata)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Last granted requester; a tie goes to the other one
    logic last_q, last_d;
    assign grant_ls = ls_req && (!if_req || last_q == OWNER_IF);
`else
    assign grant_ls = ls_req;
`endif

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MEM_ARB_IDLE;
            start_q    <= 1'b0;
            if_ack_q   <= 1'b0;
            ls_ack_q   <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            size_q     <= '0;
            wdata_q    <= '0;
            owner_q    <= OWNER_IF;
            busy_q     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q     <= OWNER_LS;
`endif
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            if_ack_q   <= if_ack_d;
            ls_ack_q   <= ls_ack_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
            owner_q    <= owner_d;
            busy_q     <= busy_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end

    // Next-state: grant in IDLE, wait for done in ISSUE, one idle cycle in RELEASE
    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        if_ack_d   = 1'b0;
        ls_ack_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        addr_d     = addr_q;
        we_d       = we_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        owner_d    = owner_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d     = last_q;
`endif
        case (state_q)
            MEM_ARB_IDLE: begin
                if (if_req || ls_req) begin
                    owner_d = grant_ls ? OWNER_LS : OWNER_IF;
                    addr_d  = grant_ls ? ls_addr : if_addr;
                    we_d    = grant_ls && ls_we;
                    size_d  = grant_ls ? coerce_size(ls_size) : SIZE_W;
                    wdata_d = grant_ls ? ls_wdata : '0;
                    start_d = 1'b1;
                    state_d = MEM_ARB_ISSUE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_d  = grant_ls ? OWNER_LS : OWNER_IF;
`endif
                end
            end
            MEM_ARB_ISSUE: begin
                if (mem_done) begin
                    start_d = 1'b0;
                    state_d = MEM_ARB_RELEASE;
                    if (owner_q == OWNER_LS) begin
                        ls_ack_d   = 1'b1;
                        ls_rdata_d = we_q ? '0 : fmt_rdata;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = fmt_rdata;
                    end
                end
            end
            MEM_ARB_RELEASE: state_d = MEM_ARB_IDLE;
            default: begin
                state_d = MEM_ARB_IDLE;
                start_d = 1'b0;
            end
        endcase
        busy_d = (state_d != MEM_ARB_IDLE);
    end

    assign if_ack        = if_ack_q;
    assign ls_ack        = ls_ack_q;
    assign if_rdata      = if_rdata_q;
    assign ls_rdata      = ls_rdata_q;
    assign mem_start     = start_q;
    assign mem_num_bytes = size_q;
    assign mem_addr      = addr_q;
    assign mem_is_write  = we_q;
    assign mem_wdata     = wdata_q;
    assign busy          = busy_q;

endmodule
